// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer: load-use / jr stalls, bubbles and branch/jal flushes.
// Optional performance counters are enabled with the HC_PERF_CNT_EN macro.
module hazard_controller #(
  parameter int unsigned AWIDTH     = 5,
  parameter int unsigned CNT_WIDTH  = 2,
  parameter int unsigned PERF_WIDTH = 16
) (
  input  logic              hc_clk,
  input  logic              hc_rst,
  input  logic              hc_i_ce,
  input  logic [AWIDTH-1:0] hc_i_id_addr_rs,
  input  logic [AWIDTH-1:0] hc_i_id_addr_rt,
  input  logic              hc_i_id_uses_rt,
  input  logic              hc_i_id_jr,
  input  logic              hc_i_id_jal,
  input  logic              hc_i_ex_reg_wr,
  input  logic              hc_i_ex_memtoreg,
  input  logic [AWIDTH-1:0] hc_i_ex_addr_wr,
  input  logic              hc_i_mem_reg_wr,
  input  logic              hc_i_mem_memtoreg,
  input  logic [AWIDTH-1:0] hc_i_mem_addr_wr,
  input  logic              hc_i_ex_branch_taken,
  output logic              hc_o_stall,
  output logic              hc_o_bubble,
  output logic              hc_o_flush_ifid,
  output logic              hc_o_flush_idex
`ifdef HC_PERF_CNT_EN
  ,
  output logic [PERF_WIDTH-1:0] hc_o_stall_cnt,
  output logic [PERF_WIDTH-1:0] hc_o_flush_cnt
`endif
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 ex_hit_rs, ex_hit_rt, mem_hit_rs;
  logic [1:0]           need;

  // Register $0 is never a real destination, so it never creates a hazard.
  assign ex_hit_rs  = hc_i_ex_reg_wr && (hc_i_ex_addr_wr != '0) &&
                      (hc_i_ex_addr_wr == hc_i_id_addr_rs);
  assign ex_hit_rt  = hc_i_ex_reg_wr && (hc_i_ex_addr_wr != '0) &&
                      (hc_i_ex_addr_wr == hc_i_id_addr_rt) && hc_i_id_uses_rt;
  assign mem_hit_rs = hc_i_mem_reg_wr && (hc_i_mem_addr_wr != '0) &&
                      (hc_i_mem_addr_wr == hc_i_id_addr_rs);

  always_comb begin
    need = 2'd0;
    if (hc_i_id_jr && ex_hit_rs && hc_i_ex_memtoreg)
      need = 2'd2;
    else if ((hc_i_ex_memtoreg && (ex_hit_rs || ex_hit_rt)) ||
             (hc_i_id_jr && ex_hit_rs) ||
             (hc_i_id_jr && mem_hit_rs && hc_i_mem_memtoreg))
      need = 2'd1;
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    hc_o_stall      = 1'b0;
    hc_o_bubble     = 1'b0;
    hc_o_flush_ifid = 1'b0;
    hc_o_flush_idex = 1'b0;
    if (hc_rst && hc_i_ce) begin
      if (hc_i_ex_branch_taken) begin
        hc_o_flush_ifid = 1'b1;
        hc_o_flush_idex = 1'b1;
        state_nxt       = FLUSH;
        cnt_nxt         = '0;
      end else begin
        case (state)
          STALL: begin
            hc_o_stall  = 1'b1;
            hc_o_bubble = 1'b1;
            if (cnt <= CNT_WIDTH'(1)) begin
              state_nxt = RUN;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt - CNT_WIDTH'(1);
            end
          end
          FLUSH: state_nxt = RUN;
          RUN: begin
            if (need != 2'd0) begin
              hc_o_stall  = 1'b1;
              hc_o_bubble = 1'b1;
              // The current cycle is the first stall cycle; STALL covers the rest.
              if (need == 2'd2) begin
                state_nxt = STALL;
                cnt_nxt   = CNT_WIDTH'(need - 2'd1);
              end
            end else if (hc_i_id_jal) begin
              hc_o_flush_ifid = 1'b1;
            end
          end
          default: state_nxt = RUN;
        endcase
      end
    end
  end

  always_ff @(posedge hc_clk) begin
    if (!hc_rst) begin
      state <= RUN;
      cnt   <= '0;
    end else if (hc_i_ce) begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef HC_PERF_CNT_EN
  always_ff @(posedge hc_clk) begin
    if (!hc_rst) begin
      hc_o_stall_cnt <= '0;
      hc_o_flush_cnt <= '0;
    end else begin
      if (hc_o_stall && (hc_o_stall_cnt != '1))
        hc_o_stall_cnt <= hc_o_stall_cnt + PERF_WIDTH'(1);
      if ((hc_o_flush_ifid || hc_o_flush_idex) && (hc_o_flush_cnt != '1))
        hc_o_flush_cnt <= hc_o_flush_cnt + PERF_WIDTH'(1);
    end
  end
`else
  logic unused_perf_width;
  assign unused_perf_width = ^PERF_WIDTH;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller; outputs are checked as
// {stall, bubble, flush_ifid, flush_idex} one time unit after inputs settle.
module tb_hazard_controller;

  logic       hc_clk = 1'b0;
  logic       hc_rst, hc_i_ce;
  logic [4:0] hc_i_id_addr_rs, hc_i_id_addr_rt, hc_i_ex_addr_wr, hc_i_mem_addr_wr;
  logic       hc_i_id_uses_rt, hc_i_id_jr, hc_i_id_jal;
  logic       hc_i_ex_reg_wr, hc_i_ex_memtoreg, hc_i_mem_reg_wr, hc_i_mem_memtoreg;
  logic       hc_i_ex_branch_taken;
  logic       hc_o_stall, hc_o_bubble, hc_o_flush_ifid, hc_o_flush_idex;
`ifdef HC_PERF_CNT_EN
  logic [15:0] hc_o_stall_cnt, hc_o_flush_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 hc_clk = ~hc_clk;

  hazard_controller #(.AWIDTH(5), .CNT_WIDTH(2), .PERF_WIDTH(16)) dut (
    .hc_clk(hc_clk), .hc_rst(hc_rst), .hc_i_ce(hc_i_ce),
    .hc_i_id_addr_rs(hc_i_id_addr_rs), .hc_i_id_addr_rt(hc_i_id_addr_rt),
    .hc_i_id_uses_rt(hc_i_id_uses_rt), .hc_i_id_jr(hc_i_id_jr), .hc_i_id_jal(hc_i_id_jal),
    .hc_i_ex_reg_wr(hc_i_ex_reg_wr), .hc_i_ex_memtoreg(hc_i_ex_memtoreg),
    .hc_i_ex_addr_wr(hc_i_ex_addr_wr), .hc_i_mem_reg_wr(hc_i_mem_reg_wr),
    .hc_i_mem_memtoreg(hc_i_mem_memtoreg), .hc_i_mem_addr_wr(hc_i_mem_addr_wr),
    .hc_i_ex_branch_taken(hc_i_ex_branch_taken),
    .hc_o_stall(hc_o_stall), .hc_o_bubble(hc_o_bubble),
    .hc_o_flush_ifid(hc_o_flush_ifid), .hc_o_flush_idex(hc_o_flush_idex)
`ifdef HC_PERF_CNT_EN
    , .hc_o_stall_cnt(hc_o_stall_cnt), .hc_o_flush_cnt(hc_o_flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {hc_o_stall, hc_o_bubble, hc_o_flush_ifid, hc_o_flush_idex};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    hc_rst = 1'b1; hc_i_ce = 1'b1;
    hc_i_id_addr_rs = '0; hc_i_id_addr_rt = '0; hc_i_id_uses_rt = 1'b0;
    hc_i_id_jr = 1'b0; hc_i_id_jal = 1'b0;
    hc_i_ex_reg_wr = 1'b0; hc_i_ex_memtoreg = 1'b0; hc_i_ex_addr_wr = '0;
    hc_i_mem_reg_wr = 1'b0; hc_i_mem_memtoreg = 1'b0; hc_i_mem_addr_wr = '0;
    hc_i_ex_branch_taken = 1'b0;
  endtask

  task automatic ex_wr(input logic [4:0] dst, input logic load);
    hc_i_ex_reg_wr = 1'b1; hc_i_ex_memtoreg = load; hc_i_ex_addr_wr = dst;
  endtask

  task automatic jr_after_lw31();
    idle(); ex_wr(5'd31, 1'b1); hc_i_id_jr = 1'b1; hc_i_id_addr_rs = 5'd31;
  endtask

  initial begin
    idle(); hc_rst = 1'b0;
    @(negedge hc_clk); ex_wr(5'd8, 1'b1); hc_i_id_addr_rs = 5'd8; #1 chk("reset_outputs", 4'b0000);
    @(negedge hc_clk); idle(); #1 chk("post_reset_idle", 4'b0000);
`ifdef HC_PERF_CNT_EN
    chk16("stall_cnt_reset", hc_o_stall_cnt, 16'h0000);
    chk16("flush_cnt_reset", hc_o_flush_cnt, 16'h0000);
`endif

    // load-use on rs
    @(negedge hc_clk); ex_wr(5'd8, 1'b1); hc_i_id_addr_rs = 5'd8; #1 chk("loaduse_rs", 4'b1100);
    @(negedge hc_clk); idle(); #1 chk("loaduse_rs_done", 4'b0000);
    @(negedge hc_clk); ex_wr(5'd0, 1'b1); hc_i_id_addr_rs = 5'd0; #1 chk("loaduse_r0", 4'b0000);

    // rt gating by uses_rt
    @(negedge hc_clk); idle(); ex_wr(5'd9, 1'b1); hc_i_id_addr_rt = 5'd9; #1 chk("rt_unused", 4'b0000);
    @(negedge hc_clk); hc_i_id_uses_rt = 1'b1; #1 chk("rt_used", 4'b1100);
    @(negedge hc_clk); idle(); #1 chk("rt_used_done", 4'b0000);

    // jr after lw: RUN stall then one STALL cycle, ID not re-evaluated
    @(negedge hc_clk); jr_after_lw31(); #1 chk("jr_lw_c1", 4'b1100);
    @(negedge hc_clk); idle(); #1 chk("jr_lw_c2", 4'b1100);
    @(negedge hc_clk); #1 chk("jr_lw_done", 4'b0000);

    // jr after addi, and jr against MEM producers
    @(negedge hc_clk); idle(); ex_wr(5'd31, 1'b0); hc_i_id_jr = 1'b1; hc_i_id_addr_rs = 5'd31;
    #1 chk("jr_addi", 4'b1100);
    @(negedge hc_clk); idle(); #1 chk("jr_addi_done", 4'b0000);
    @(negedge hc_clk); hc_i_id_jr = 1'b1; hc_i_id_addr_rs = 5'd4;
    hc_i_mem_reg_wr = 1'b1; hc_i_mem_memtoreg = 1'b1; hc_i_mem_addr_wr = 5'd4;
    #1 chk("jr_mem_load", 4'b1100);
    @(negedge hc_clk); hc_i_mem_memtoreg = 1'b0; #1 chk("jr_mem_alu", 4'b0000);
    @(negedge hc_clk); idle(); ex_wr(5'd5, 1'b0); hc_i_id_addr_rs = 5'd5; #1 chk("alu_no_jr", 4'b0000);

    // taken branch during STALL, then FLUSH (jal suppressed), then RUN
    @(negedge hc_clk); jr_after_lw31(); #1 chk("br_stall_c1", 4'b1100);
    @(negedge hc_clk); idle(); hc_i_ex_branch_taken = 1'b1; #1 chk("br_in_stall", 4'b0011);
    @(negedge hc_clk); idle(); hc_i_id_jal = 1'b1; #1 chk("flush_state", 4'b0000);
    @(negedge hc_clk); #1 chk("jal_after_flush", 4'b0010);
    @(negedge hc_clk); idle(); #1 chk("jal_one_cycle", 4'b0000);

    // branch while in FLUSH keeps FLUSH; branch beats a RUN hazard
    @(negedge hc_clk); ex_wr(5'd8, 1'b1); hc_i_id_addr_rs = 5'd8; hc_i_ex_branch_taken = 1'b1;
    #1 chk("br_over_hazard", 4'b0011);
    @(negedge hc_clk); idle(); hc_i_ex_branch_taken = 1'b1; #1 chk("br_in_flush", 4'b0011);
    @(negedge hc_clk); idle(); hc_i_id_jal = 1'b1; #1 chk("still_flush", 4'b0000);
    @(negedge hc_clk); ex_wr(5'd8, 1'b1); hc_i_id_addr_rs = 5'd8; #1 chk("stall_over_jal", 4'b1100);

    // ce=0 mid-STALL freezes state/count
    @(negedge hc_clk); jr_after_lw31(); #1 chk("ce_stall_c1", 4'b1100);
    @(negedge hc_clk); idle(); hc_i_ce = 1'b0; #1 chk("ce_low_a", 4'b0000);
    @(negedge hc_clk); hc_i_id_jal = 1'b1; #1 chk("ce_low_b", 4'b0000);
    @(negedge hc_clk); idle(); #1 chk("ce_resume", 4'b1100);
    @(negedge hc_clk); hc_i_id_jal = 1'b1; #1 chk("ce_back_run", 4'b0010);

    // reset mid-STALL abandons the stall
    @(negedge hc_clk); jr_after_lw31(); #1 chk("rst_stall_c1", 4'b1100);
    @(negedge hc_clk); idle(); hc_rst = 1'b0; #1 chk("rst_mid_stall", 4'b0000);
    @(negedge hc_clk); idle(); hc_i_id_jal = 1'b1; #1 chk("rst_to_run", 4'b0010);

`ifdef HC_PERF_CNT_EN
    @(negedge hc_clk); idle(); hc_rst = 1'b0;
    @(negedge hc_clk); idle(); #1;
    chk16("stall_cnt_clear", hc_o_stall_cnt, 16'h0000);
    chk16("flush_cnt_clear", hc_o_flush_cnt, 16'h0000);
    ex_wr(5'd8, 1'b1); hc_i_id_addr_rs = 5'd8;
    repeat (65540) @(negedge hc_clk);
    #1;
    chk16("stall_cnt_sat", hc_o_stall_cnt, 16'hFFFF);
    chk16("flush_cnt_idle", hc_o_flush_cnt, 16'h0000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline hazard sequencer for the 5-stage MIPS core. Sits beside the decode stage and compares ID-stage source registers against destinations in flight in EX and MEM.
- Drives PC/IF-ID hold, ID-EX bubble insertion and IF-ID/ID-EX flush.
- Sequences multi-cycle stalls (load-use, jr dependency) with an FSM and cancels them on taken-branch redirect.

Parameters:
- AWIDTH, 5, register address width.
- CNT_WIDTH, 2, stall down-counter width (maximum stall 2 cycles).
- PERF_WIDTH, 16, width of performance counters (optional feature only).

Ports:
- hc_clk  in  1  clock, all state updates on rising edge
- hc_rst  in  1  synchronous active-low reset
- hc_i_ce  in  1  stage enable; when low, FSM holds and all control outputs are 0
- hc_i_id_addr_rs  in  AWIDTH  rs of instruction in ID
- hc_i_id_addr_rt  in  AWIDTH  rt of instruction in ID
- hc_i_id_uses_rt  in  1  ID instruction reads rt (R-type, store, branch)
- hc_i_id_jr  in  1  ID instruction is jr (reads rs in ID)
- hc_i_id_jal  in  1  ID instruction is jal (redirect resolved in ID)
- hc_i_ex_reg_wr  in  1  EX instruction writes register file
- hc_i_ex_memtoreg  in  1  EX instruction is a load
- hc_i_ex_addr_wr  in  AWIDTH  EX destination register
- hc_i_mem_reg_wr  in  1  MEM instruction writes register file
- hc_i_mem_memtoreg  in  1  MEM instruction is a load
- hc_i_mem_addr_wr  in  AWIDTH  MEM destination register
- hc_i_ex_branch_taken  in  1  branch resolved taken in EX
- hc_o_stall  out  1  hold PC and IF/ID
- hc_o_bubble  out  1  zero control fields into ID/EX
- hc_o_flush_ifid  out  1  invalidate IF/ID
- hc_o_flush_idex  out  1  invalidate ID/EX

Behaviour:
- Reset (hc_rst low at edge): state RUN, count 0, all outputs 0. Reset mid-stall abandons the stall.
- Destination register 0 never matches. Matches use only non-zero addresses qualified by the corresponding reg_wr.
- Stall need N, computed combinationally in RUN. The largest applicable value wins:
  - EX load writes rs, or writes rt with uses_rt: N=1.
  - jr and EX writes rs: N=2 if the EX instruction is a load, else N=1.
  - jr and MEM load writes rs: N=1.
  - Otherwise N=0.
- FSM states: RUN, STALL, FLUSH.
- RUN:
  - N>0: hc_o_stall=hc_o_bubble=1 this cycle. If N=2, go to STALL with count=1; else stay in RUN.
  - N=0: no stall.
- STALL: hc_o_stall=hc_o_bubble=1. count decrements each cycle; return to RUN when count reaches 0 after this cycle. ID inputs are not re-evaluated in STALL.
- Taken branch (hc_i_ex_branch_taken=1, any state):
  - hc_o_flush_ifid=hc_o_flush_idex=1 in the same cycle.
  - stall/bubble forced 0; any pending stall is cancelled; next state is FLUSH.
- FLUSH: one cycle, all outputs 0 (the ID slot is already invalid), then RUN. A taken branch during FLUSH reasserts both flushes and stays in FLUSH.
- jal in ID with no stall and no taken branch: hc_o_flush_ifid=1 for that cycle only. Stall takes priority over jal flush.
- Priority, highest first: reset, taken branch, STALL state, RUN hazard, jal flush.
- hc_i_ce=0: outputs 0, state and count frozen.
- Outputs are combinational from state and inputs, with zero-cycle latency. State is registered.

Optional Feature:
- Macro HC_PERF_CNT_EN.
- Defined: adds outputs hc_o_stall_cnt and hc_o_flush_cnt (PERF_WIDTH each).
  - Each increments once per cycle in which hc_o_stall, or either flush output, is 1.
  - Both saturate at all-ones and clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load-use: EX lw to $8, ID add reading rs=$8 -> stall=bubble=1 for exactly 1 cycle, then 0. Same case with ID rs=$0 and EX dest=$0 -> no stall.
- jr after lw: EX lw $31, ID jr $31 -> stall=1 for 2 consecutive cycles (RUN then STALL), then RUN. jr after addi to $31 -> 1 cycle.
- Taken branch during STALL: during cycle 2 of a jr stall, assert branch_taken -> both flushes=1, stall=0 that cycle, 1 FLUSH cycle, then RUN.
- rt gating: EX lw to $9, ID rt=$9 with uses_rt=0 -> no stall; uses_rt=1 -> 1-cycle stall.
- jal plus ce: ID jal -> flush_ifid=1 for 1 cycle. With ce=0 mid-STALL, outputs are 0 and stall resumes for its remaining cycle after ce returns to 1.
- Reset mid-STALL (hc_rst=0 for 1 edge) -> all outputs 0 and state RUN. With HC_PERF_CNT_EN, counters read 0 after reset and saturate at 16'hFFFF under forced continuous stall.
